// File: rtl/debounce_filter_pkg.sv
// Shared FSM encodings and defaults for the debounce filter.
package debounce_filter_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/debounce_filter_sync_2ff.sv
// Two-flop synchronizer bringing the raw button level into the clk domain.
// Both flops reset to RESET_LEVEL so the filter sees a settled level after reset.
module sync_2ff #(
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_LEVEL;
      q    <= RESET_LEVEL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_filter.sv
// Debounces a bouncy button: optional 2-flop synchronizer (DEBOUNCE_SYNC_EN) feeding a
// four-state FSM that requires DEBOUNCE_CYCLES consecutive equal samples to change btn_db.
module debounce_filter
  import debounce_filter_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic RESET_LEVEL     = 1'b0,
  parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_db,
  output logic bouncing
);

  localparam logic [CNT_W-1:0] TERM_CNT  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
  localparam db_state_t        RST_STATE = RESET_LEVEL ? IDLE_HIGH : IDLE_LOW;

  logic             s;
  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             db_nxt;

`ifdef DEBOUNCE_SYNC_EN
  sync_2ff #(.RESET_LEVEL(RESET_LEVEL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (s)
  );
`else
  assign s = btn_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RST_STATE;
      cnt    <= '0;
      btn_db <= RESET_LEVEL;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      btn_db <= db_nxt;
    end
  end

  // A reversal of s inside a WAIT state is checked before terminal count,
  // so the sample on the terminal edge decides the outcome.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    db_nxt    = btn_db;
    case (state)
      IDLE_LOW: begin
        if (s) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = ONE_CNT;
        end else begin
          cnt_nxt = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == TERM_CNT) begin
          state_nxt = IDLE_HIGH;
          db_nxt    = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ONE_CNT;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = ONE_CNT;
        end else begin
          cnt_nxt = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == TERM_CNT) begin
          state_nxt = IDLE_LOW;
          db_nxt    = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ONE_CNT;
        end
      end
      default: begin
        state_nxt = RST_STATE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bouncing = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

// File: doc/debounce_filter.md
# debounce_filter

- Conditions a raw, asynchronous, bouncy input (push-button or switch) into a clean, single-clock-domain level.
- Sits directly upstream of `neg_edge_detector` and drives its `signal` input, so each physical press or release produces exactly one edge downstream.
- Logic: a two-flop synchronizer feeds a four-state debounce FSM with a stability counter.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required before the output changes. Legal range 2..65535.
- `RESET_LEVEL`, default 0: level of `btn_db` and of the synchronizer flops under reset.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: counter width. Derived from `DEBOUNCE_CYCLES`; not overridden by users.
- `clk  input  1  system clock; all state updates on the rising edge`
- `rst  input  1  synchronous, active-high reset`
- `btn_in  input  1  raw asynchronous input, may bounce`
- `btn_db  output  1  debounced level; feeds neg_edge_detector.signal`
- `bouncing  output  1  high while a candidate change is being qualified (FSM in a WAIT state)`

## Operation
- Sample `s` is the synchronizer output: `btn_in` delayed by 2 flops.
- FSM states: `IDLE_LOW`, `WAIT_HIGH`, `IDLE_HIGH`, `WAIT_LOW`.
- `IDLE_LOW`:
  - `s`=1 → `WAIT_HIGH`, cnt=1.
  - Otherwise stay, cnt=0.
- `WAIT_HIGH`:
  - `s`=0 → `IDLE_LOW`, cnt=0 (glitch rejected; `btn_db` unchanged).
  - `s`=1 and cnt==`DEBOUNCE_CYCLES`-1 → `IDLE_HIGH`, `btn_db`<=1, cnt=0.
  - Otherwise cnt++.
- `IDLE_HIGH` and `WAIT_LOW` mirror the above with polarities swapped.
- `btn_db` is a registered output that changes only on an `IDLE_*` entry from a `WAIT_*` state.
- `bouncing` = (state==`WAIT_HIGH` || state==`WAIT_LOW`), decoded from registered state.
- Counter never exceeds `DEBOUNCE_CYCLES`-1 and never wraps.
- Any reversal of `s` during a WAIT state restarts qualification from zero.

## Timing
- Reset, synchronous, checked on each rising edge while `rst`=1:
  - Sync flops = `RESET_LEVEL`.
  - State = `IDLE_LOW` if `RESET_LEVEL`=0, else `IDLE_HIGH`.
  - cnt=0, `btn_db`=`RESET_LEVEL`, `bouncing`=0.
- Reset asserted mid-WAIT aborts qualification; after release the FSM starts from the idle state at the reset level.
- Latency with synchronizer, raw change settling before edge k:
  - `s` changes after edge k+1.
  - FSM enters WAIT at edge k+2.
  - `btn_db` toggles at edge k+1+`DEBOUNCE_CYCLES`. With the default of 4, that is edge k+5.
- Minimum stable pulse width to propagate: `DEBOUNCE_CYCLES` clocks as seen at `s`. Shorter pulses produce no `btn_db` change and set `bouncing` for their duration plus 2 clocks of sync delay.
- If `btn_in` changes on the same edge the counter reaches terminal count, the sample at that edge decides the outcome.

## Configuration
- Macro: `DEBOUNCE_SYNC_EN`.
- Defined: the 2-flop synchronizer is instantiated, with latency as above.
- Undefined:
  - `s` = `btn_in` directly, for benches driving synchronous stimulus.
  - FSM enters WAIT at edge k; `btn_db` toggles at edge k+`DEBOUNCE_CYCLES`-1, 2 cycles earlier.
  - All other behaviour is identical.

## Structure
- Shared package/header:
  - FSM state encodings (2-bit: `IDLE_LOW`=0, `WAIT_HIGH`=1, `IDLE_HIGH`=2, `WAIT_LOW`=3).
  - Default `DEBOUNCE_CYCLES` constant.
- One sub-module, `sync_2ff` (parameter `RESET_LEVEL`; ports `clk`, `rst`, `d`, `q`), instantiated only under `DEBOUNCE_SYNC_EN`.
- FSM and counter stay in `debounce_filter`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, 10 ns clock, `DEBOUNCE_SYNC_EN` defined, unless noted.
- Reset: hold `rst`=1 for 3 clocks with `btn_in`=1 → `btn_db`=0 and `bouncing`=0 throughout; after release, `btn_db` rises 5 edges later.
- Clean press: `btn_in` 0→1 before edge 10, held → `bouncing`=1 from edge 12 to 15; `btn_db`=1 after edge 15. Release 0 before edge 30 → `btn_db`=0 after edge 35.
- Bounce rejection: `btn_in` toggles 1,0,1,0 every clock for 8 clocks, then 0 → `btn_db` stays 0; `bouncing` pulses; downstream `neg_edge` never asserts.
- Glitch then hold: 2-cycle high, 1-cycle low, then high held → `btn_db` rises exactly 5 edges after the final rising transition, once.
- Reset mid-qualification: assert `rst` while in `WAIT_HIGH` with cnt=2 → after reset, state `IDLE_LOW`, cnt=0, `btn_db`=0.
- Macro off: same clean press as above → `btn_db`=1 after edge 13.
